// File: rtl/tx_sequencer.sv
// Frame sequencer: streams preamble, sync word, length header and RAM payload
// to the byte serializer with a valid/ready handshake.
module tx_sequencer #(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
    parameter logic [15:0] SYNC_WORD     = 16'h2DD4,
    parameter int unsigned RAM_DEPTH     = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_transmit,
    input  logic [9:0] i_msg_length,
    input  logic [7:0] i_ram_data,
    output logic       o_rd,
    output logic [9:0] o_ram_addr,
    output logic [7:0] o_byte,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_tx_done
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned SW = 4;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        SYNC,
        HDR,
        FETCH,
        RAMWAIT,
        SEND,
        DONE
    } state_t;

    state_t        state, state_nx;
    logic [SW-1:0] sub, sub_nx;
    logic [AW-1:0] cnt, cnt_nx;
    logic [AW-1:0] len, len_nx;
    logic [AW-1:0] addr_nx;
    logic [DW-1:0] byte_nx;
    logic          valid_nx, rd_nx, done_nx, busy_nx;
    logic          prev;
    logic          accept;
    logic          start;
    logic [AW-1:0] len_clamp;
    logic [AW-1:0] cnt_inc;

    assign accept    = o_valid && i_ready;
    assign start     = i_transmit && !prev;
    assign len_clamp = (i_msg_length > AW'(RAM_DEPTH)) ? AW'(RAM_DEPTH) : i_msg_length;
    assign cnt_inc   = cnt + AW'(1);

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sub        <= '0;
            cnt        <= '0;
            len        <= '0;
            prev       <= 1'b0;
            o_rd       <= 1'b0;
            o_ram_addr <= '0;
            o_byte     <= '0;
            o_valid    <= 1'b0;
            o_busy     <= 1'b0;
            o_tx_done  <= 1'b0;
        end else begin
            state      <= state_nx;
            sub        <= sub_nx;
            cnt        <= cnt_nx;
            len        <= len_nx;
            prev       <= i_transmit;
            o_rd       <= rd_nx;
            o_ram_addr <= addr_nx;
            o_byte     <= byte_nx;
            o_valid    <= valid_nx;
            o_busy     <= busy_nx;
            o_tx_done  <= done_nx;
        end
    end

    // Next state; each transition preloads the byte the next state presents
    always_comb begin
        state_nx = state;
        sub_nx   = sub;
        cnt_nx   = cnt;
        len_nx   = len;
        addr_nx  = o_ram_addr;
        byte_nx  = o_byte;
        valid_nx = o_valid;
        rd_nx    = 1'b0;
        done_nx  = 1'b0;

        case (state)
            IDLE: begin
                valid_nx = 1'b0;
                if (start) begin
                    state_nx = PREAMBLE;
                    len_nx   = len_clamp;
                    cnt_nx   = '0;
                    addr_nx  = '0;
                    sub_nx   = '0;
                    byte_nx  = PREAMBLE_BYTE;
                    valid_nx = 1'b1;
                end
            end
            PREAMBLE: begin
                if (accept) begin
                    if (sub == SW'(PREAMBLE_LEN - 1)) begin
                        state_nx = SYNC;
                        sub_nx   = '0;
                        byte_nx  = SYNC_WORD[15:8];
                    end else begin
                        sub_nx  = sub + SW'(1);
                        byte_nx = PREAMBLE_BYTE;
                    end
                end
            end
            SYNC: begin
                if (accept) begin
                    if (sub == '0) begin
                        sub_nx  = SW'(1);
                        byte_nx = SYNC_WORD[7:0];
                    end else begin
                        state_nx = HDR;
                        sub_nx   = '0;
                        byte_nx  = {6'b0, len[9:8]};
                    end
                end
            end
            HDR: begin
                if (accept) begin
                    if (sub == '0) begin
                        sub_nx  = SW'(1);
                        byte_nx = len[7:0];
                    end else begin
                        valid_nx = 1'b0;
                        if (len != '0) begin
                            state_nx = FETCH;
                            rd_nx    = 1'b1;
                            addr_nx  = cnt;
                        end else begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                        end
                    end
                end
            end
            FETCH: begin
                state_nx = RAMWAIT;
            end
            RAMWAIT: begin
                state_nx = SEND;
                byte_nx  = i_ram_data;
                valid_nx = 1'b1;
            end
            SEND: begin
                if (accept) begin
                    cnt_nx   = cnt_inc;
                    valid_nx = 1'b0;
                    if (cnt_inc == len) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = FETCH;
                        rd_nx    = 1'b1;
                        addr_nx  = cnt_inc;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// Scoreboard bench for tx_sequencer: expected frame bytes are queued at
// stimulus time and a negedge monitor checks every accepted byte.
module tb_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_transmit;
    logic [9:0] i_msg_length;
    logic [7:0] i_ram_data;
    logic       o_rd;
    logic [9:0] o_ram_addr;
    logic [7:0] o_byte;
    logic       o_valid;
    logic       i_ready;
    logic       o_busy;
    logic       o_tx_done;

    tx_sequencer dut (
        .clk(clk), .reset_n(reset_n), .i_transmit(i_transmit),
        .i_msg_length(i_msg_length), .i_ram_data(i_ram_data),
        .o_rd(o_rd), .o_ram_addr(o_ram_addr), .o_byte(o_byte),
        .o_valid(o_valid), .i_ready(i_ready), .o_busy(o_busy),
        .o_tx_done(o_tx_done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:999];
    logic [7:0] exp_q [$];
    int  checks = 0;
    int  errors = 0;
    int  exp_addr = 0;
    int  rd_cnt = 0;
    int  acc_cnt = 0;
    int  done_cnt = 0;
    bit  rand_ready = 0;

    // Synchronous-read RAM model
    always @(posedge clk) if (o_rd) i_ram_data <= mem[o_ram_addr];

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: handshake, stall stability, RAM reads, done pulses
    initial begin : monitor
        bit         stalled;
        logic [7:0] stall_byte;
        logic [7:0] e;
        stalled = 0;
        stall_byte = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stalled = 0;
            end else begin
                if (o_rd) begin
                    checks++;
                    if (int'(o_ram_addr) != exp_addr || o_ram_addr > 10'd999) begin
                        errors++;
                        $display("FAIL rd_addr: got %0d want %0d", o_ram_addr, exp_addr);
                    end
                    exp_addr++;
                    rd_cnt++;
                end
                if (stalled) begin
                    checks++;
                    if (!o_valid || o_byte !== stall_byte) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%0b byte=%02h want valid=1 byte=%02h",
                                 o_valid, o_byte, stall_byte);
                    end
                end
                if (o_valid && i_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL extra_byte: got %02h want none", o_byte);
                    end else begin
                        e = exp_q.pop_front();
                        if (o_byte !== e) begin
                            errors++;
                            $display("FAIL byte[%0d]: got %02h want %02h", acc_cnt, o_byte, e);
                        end
                    end
                    acc_cnt++;
                end
                stalled = o_valid && !i_ready;
                stall_byte = o_byte;
                if (o_tx_done) done_cnt++;
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_frame(input int unsigned l);
        logic [9:0] lv;
        lv = 10'(l);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'h2D);
        exp_q.push_back(8'hD4);
        exp_q.push_back({6'b0, lv[9:8]});
        exp_q.push_back(lv[7:0]);
        for (int i = 0; i < int'(l); i++) exp_q.push_back(mem[i]);
    endtask

    // mode 0: pulse transmit, 1: hold high, 2: re-edge while busy then hold
    task automatic run_frame(input int unsigned len, input bit rnd, input int mode);
        int unsigned l;
        int d0;
        int n;
        l = (len > 1000) ? 1000 : len;
        push_frame(l);
        exp_addr = 0;
        rd_cnt = 0;
        acc_cnt = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        i_msg_length = 10'(len);
        i_transmit = 1'b1;
        rand_ready = rnd;
        @(posedge clk); #1;
        i_msg_length = ~10'(len);
        check("busy_after_start", int'(o_busy), 1);
        if (mode == 0) begin
            repeat (2) @(posedge clk);
            #1 i_transmit = 1'b0;
        end else if (mode == 2) begin
            repeat (10) @(posedge clk);
            #1 i_transmit = 1'b0;
            repeat (2) @(posedge clk);
            #1 i_transmit = 1'b1;
        end
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("done_timeout", int'(n < 20000), 1);
        repeat (3) @(posedge clk);
        #1;
        rand_ready = 0;
        i_ready = 1'b1;
        check("done_pulses", done_cnt - d0, 1);
        check("left_bytes", exp_q.size(), 0);
        check("rd_count", rd_cnt, int'(l));
        check("idle_busy", int'(o_busy), 0);
        exp_q.delete();
    endtask

    initial begin : stim
        int d0;
        int n;
        reset_n = 1'b0;
        i_transmit = 1'b0;
        i_msg_length = '0;
        i_ready = 1'b1;
        i_ram_data = '0;
        for (int i = 0; i < 1000; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 3));
        mem[0] = 8'hA1;
        mem[1] = 8'hB2;
        mem[2] = 8'hC3;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_rd", int'(o_rd), 0);
        check("rst_done", int'(o_tx_done), 0);
        check("rst_byte", int'(o_byte), 0);
        check("rst_addr", int'(o_ram_addr), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        run_frame(3, 0, 0);
        run_frame(0, 0, 0);
        run_frame(1023, 0, 0);
        run_frame(37, 1, 0);

        // Held-high transmit must not retrigger
        run_frame(2, 0, 1);
        d0 = done_cnt;
        repeat (20) @(posedge clk);
        #1;
        check("hold_no_retrigger_busy", int'(o_busy), 0);
        check("hold_no_retrigger_done", done_cnt - d0, 0);
        i_transmit = 1'b0;
        repeat (2) @(posedge clk);

        // Edge while busy is ignored
        run_frame(5, 0, 2);
        d0 = done_cnt;
        repeat (30) @(posedge clk);
        #1;
        check("busy_edge_busy", int'(o_busy), 0);
        check("busy_edge_done", done_cnt - d0, 0);
        i_transmit = 1'b0;
        repeat (2) @(posedge clk);

        // Async reset in the middle of the payload
        push_frame(10);
        exp_addr = 0;
        acc_cnt = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        i_msg_length = 10'd10;
        i_transmit = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_transmit = 1'b0;
        n = 0;
        while (acc_cnt < 12 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("rst_mid_reach", int'(n < 2000), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", int'(o_valid), 0);
        check("rst_mid_busy", int'(o_busy), 0);
        check("rst_mid_rd", int'(o_rd), 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        exp_q.delete();
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt - d0, 0);
        check("rst_mid_idle", int'(o_busy), 0);
        run_frame(10, 0, 0);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_sequencer.md
Name: tx_sequencer

Overview:
- Frames and streams one stored message out of the 1000-byte message RAM to the modulator's byte serializer.
- Starts on a rising edge of the control register block's transmit flag.
- Emits, in order: preamble, sync word, 2-byte length header, then payload bytes read from the RAM.
- Pulses tx_done when the last byte is accepted; control then clears transmit.
- Owns the RAM read port on the modem side; the SPI side uses the other port.

Parameters:
- PREAMBLE_LEN, 4, number of preamble bytes (1..15).
- PREAMBLE_BYTE, 8'h55, preamble byte value.
- SYNC_WORD, 16'h2DD4, sync word; sent MSB byte first.
- RAM_DEPTH, 1000, payload bytes available in RAM; the length is clamped to this.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- i_transmit  in  1  transmit flag from control (level)
- i_msg_length  in  10  payload length in bytes
- i_ram_data  in  8  RAM read data, valid one cycle after o_rd
- o_rd  out  1  RAM read strobe
- o_ram_addr  out  10  RAM read address
- o_byte  out  8  byte to serializer
- o_valid  out  1  o_byte valid
- i_ready  in  1  serializer accepts o_byte when o_valid && i_ready
- o_busy  out  1  high in any state other than IDLE
- o_tx_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset_n low, async): state IDLE; o_rd=0, o_ram_addr=0, o_byte=0, o_valid=0, o_busy=0, o_tx_done=0; the registered copy of i_transmit is cleared to 0.
- Start condition: i_transmit registered; start = i_transmit && !prev, sampled only in IDLE. A level held high does not retrigger; an edge while busy is ignored.
- On start:
  - latch len = min(i_msg_length, RAM_DEPTH);
  - clear byte counter and address;
  - go to PREAMBLE.
- Byte handshake, all streaming states:
  - o_byte and o_valid are registered and held stable while o_valid && !i_ready;
  - advance only on acceptance (o_valid && i_ready).
- PREAMBLE: send PREAMBLE_BYTE PREAMBLE_LEN times, then go to SYNC.
- SYNC: send SYNC_WORD[15:8], then SYNC_WORD[7:0], then go to HDR.
- HDR: send {6'b0, len[9:8]}, then len[7:0]. Then go to FETCH if len != 0, else DONE.
- FETCH (1 cycle): o_rd=1, o_ram_addr=counter; o_valid=0. Next state RAMWAIT.
- RAMWAIT (1 cycle): o_byte <= i_ram_data, o_valid <= 1. Next state SEND.
- SEND: on acceptance, counter++. If the new counter == len, go to DONE; else go to FETCH. Payload rate is at most 1 byte per 3 clocks.
- DONE (1 cycle): o_tx_done=1, o_valid=0, then go to IDLE.
- o_rd is high only in FETCH; o_ram_addr holds its last value otherwise.
- The counter is 10 bits; len ≤ 1000, so the address never exceeds 999 and never wraps.
- i_msg_length changes after start have no effect on the frame in progress.
- i_transmit falling mid-frame has no effect; the frame always completes.
- Frame length in bytes = PREAMBLE_LEN + 2 + 2 + len.
- Async reset mid-frame: immediate return to IDLE, no o_tx_done pulse, o_valid drops.

Test Plan:
- Reset, i_ready=1, len=3, RAM[0..2]=A1,B2,C3, pulse i_transmit → stream 55,55,55,55,2D,D4,00,03,A1,B2,C3; o_rd seen at addr 0,1,2; single o_tx_done one cycle after the C3 acceptance.
- len=0 → stream 55×4,2D,D4,00,00; no o_rd assertions; o_tx_done pulses.
- len=1023 → header 03,E8; exactly 1000 payload bytes from addr 0..999; o_ram_addr never exceeds 999.
- i_ready toggling 0/1 pseudo-randomly during payload → o_byte/o_valid stable while stalled; no byte lost or duplicated versus the RAM contents.
- i_transmit held high after done, then a second rising edge while busy → exactly one frame per IDLE-sampled edge; the edge during busy produces no extra frame.
- reset_n asserted during the payload phase (byte 5 of 10) → o_valid=0 and o_busy=0 immediately, no o_tx_done; after release, a new edge gives a full frame starting at preamble.
